// File: rtl/mrnaiso_pkg.sv
// Shared types and constants for the mRNA isolation chip valve sequencer:
// FSM state encoding, valve vector layout, pump pattern and per-state open masks.
package mrnaiso_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRIME      = 3'd1,
        LOAD_CELLS = 3'd2,
        LOAD_LYSIS = 3'd3,
        MIX        = 3'd4,
        SEPARATE   = 3'd5,
        ELUTE      = 3'd6
    } state_t;

    localparam int NUM_VALVES = 13;

    localparam int V_CELLS_IN  = 0;
    localparam int V_CELLS_OUT = 1;
    localparam int V_PUSH      = 2;
    localparam int V_PUMP1     = 3;
    localparam int V_PUMP2     = 4;
    localparam int V_PUMP3     = 5;
    localparam int V_LYSIS_IN  = 6;
    localparam int V_LYSIS_OUT = 7;
    localparam int V_SEP       = 8;
    localparam int V_BEADS     = 9;
    localparam int V_SIEVE     = 10;
    localparam int V_COLLECT   = 11;
    localparam int V_WASTE     = 12;

    // {pump1,pump2,pump3} per phase; index 0 is the rightmost entry.
    localparam logic [5:0][2:0] PUMP_PATTERN = {
        3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101
    };

    localparam logic [NUM_VALVES-1:0] VONE = NUM_VALVES'(1);

    // A set bit means the valve is open (air line vented).
    localparam logic [NUM_VALVES-1:0] OPEN_NONE       = '0;
    localparam logic [NUM_VALVES-1:0] OPEN_PRIME      = VONE << V_BEADS;
    localparam logic [NUM_VALVES-1:0] OPEN_LOAD_CELLS = (VONE << V_CELLS_IN)
                                                      | (VONE << V_CELLS_OUT);
    localparam logic [NUM_VALVES-1:0] OPEN_LOAD_LYSIS = (VONE << V_LYSIS_IN)
                                                      | (VONE << V_PUMP3)
                                                      | (VONE << V_LYSIS_OUT);
    localparam logic [NUM_VALVES-1:0] OPEN_SEPARATE   = (VONE << V_PUSH)
                                                      | (VONE << V_PUMP1)
                                                      | (VONE << V_SEP)
                                                      | (VONE << V_SIEVE)
                                                      | (VONE << V_WASTE);
    localparam logic [NUM_VALVES-1:0] OPEN_ELUTE      = (VONE << V_PUSH)
                                                      | (VONE << V_PUMP1)
                                                      | (VONE << V_SEP)
                                                      | (VONE << V_SIEVE)
                                                      | (VONE << V_COLLECT);

    function automatic logic [NUM_VALVES-1:0] open_mask(input state_t s);
        case (s)
            PRIME:      return OPEN_PRIME;
            LOAD_CELLS: return OPEN_LOAD_CELLS;
            LOAD_LYSIS: return OPEN_LOAD_LYSIS;
            SEPARATE:   return OPEN_SEPARATE;
            ELUTE:      return OPEN_ELUTE;
            default:    return OPEN_NONE;
        endcase
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mrnaiso_valve_seq_phase_gen.sv
// Peristaltic pump phase generator: six-phase pattern, PHASE_CYC cycles per
// phase, counts completed strokes and flags the end of the last one.
module peristaltic_phase_gen
    import mrnaiso_pkg::*;
#(
    parameter int PHASE_CYC   = 8,
    parameter int MIX_STROKES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clear,
    input  logic       hold,
    output logic [2:0] pump,
    output logic       stroke_done
);

    localparam int PC_W = $clog2(PHASE_CYC) + 1;
    localparam int SC_W = $clog2(MIX_STROKES) + 1;

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PHASE_CYC - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(MIX_STROKES - 1);
    localparam logic [2:0]      PH_LAST = 3'd5;

    logic [PC_W-1:0] phase_cnt;
    logic [2:0]      phase;
    logic [SC_W-1:0] stroke_cnt;
    logic            step;
    logic            phase_end;
    logic            wrap;

    assign step      = enable && !hold;
    assign phase_end = (phase_cnt == PC_LAST);
    assign wrap      = phase_end && (phase == PH_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt  <= '0;
            phase      <= '0;
            stroke_cnt <= '0;
        end else if (clear) begin
            phase_cnt  <= '0;
            phase      <= '0;
            stroke_cnt <= '0;
        end else if (step) begin
            if (phase_end) begin
                phase_cnt <= '0;
                if (wrap) begin
                    phase      <= '0;
                    stroke_cnt <= stroke_cnt + SC_W'(1);
                end else begin
                    phase <= phase + 3'd1;
                end
            end else begin
                phase_cnt <= phase_cnt + PC_W'(1);
            end
        end
    end

    assign pump        = PUMP_PATTERN[phase];
    assign stroke_done = step && wrap && (stroke_cnt == SC_LAST);

endmodule

// File: rtl/mrnaiso_valve_seq.sv
// Pneumatic protocol sequencer for the mRNA isolation chip; every valve output
// is registered. Optional MRNAISO_HOLD_EN adds a `hold` input that freezes a run.
module mrnaiso_valve_seq
    import mrnaiso_pkg::*;
#(
    parameter int PHASE_CYC   = 8,
    parameter int PRIME_CYC   = 16,
    parameter int LOAD_CYC    = 16,
    parameter int MIX_STROKES = 4,
    parameter int SEP_CYC     = 32,
    parameter int ELUTE_CYC   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
`ifdef MRNAISO_HOLD_EN
    input  logic       hold,
`endif
    output logic       cells_in_ctrl,
    output logic       cells_out_ctrl,
    output logic       push_ctrl,
    output logic       pump1,
    output logic       pump2,
    output logic       pump3,
    output logic       lysis_in_ctrl,
    output logic       lysis_out_ctrl,
    output logic       sep_ctrl,
    output logic       beads_ctrl,
    output logic       sieve_ctrl,
    output logic       collect_ctrl,
    output logic       waste_ctrl,
    output logic       busy,
    output logic       done,
    output logic [2:0] state
);

    localparam int MIX_TOTAL = MIX_STROKES * 6 * PHASE_CYC;
    localparam int MAX_CNT   = max2(max2(max2(PRIME_CYC, LOAD_CYC), max2(SEP_CYC, ELUTE_CYC)),
                                    MIX_TOTAL);
    localparam int CNT_W     = $clog2(MAX_CNT) + 1;

    state_t                  state_q, state_next;
    logic [CNT_W-1:0]        cnt_q, cnt_next;
    logic [NUM_VALVES-1:0]   valves_q, valves_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    hold_act;
    logic                    abort_run;
    logic [2:0]              pump;
    logic                    stroke_done;

`ifdef MRNAISO_HOLD_EN
    assign hold_act = hold && (state_q != IDLE);
`else
    assign hold_act = 1'b0;
`endif

    assign abort_run = abort && (state_q != IDLE);

    function automatic logic [CNT_W-1:0] dwell_m1(input state_t s);
        case (s)
            PRIME:                  return CNT_W'(PRIME_CYC - 1);
            LOAD_CELLS, LOAD_LYSIS: return CNT_W'(LOAD_CYC - 1);
            SEPARATE:               return CNT_W'(SEP_CYC - 1);
            ELUTE:                  return CNT_W'(ELUTE_CYC - 1);
            default:                return '0;
        endcase
    endfunction

    function automatic state_t seq_next(input state_t s);
        case (s)
            PRIME:      return LOAD_CELLS;
            LOAD_CELLS: return LOAD_LYSIS;
            LOAD_LYSIS: return MIX;
            MIX:        return SEPARATE;
            SEPARATE:   return ELUTE;
            default:    return IDLE;
        endcase
    endfunction

    function automatic logic [NUM_VALVES-1:0] state_valves(input state_t s,
                                                           input logic [2:0] pumps);
        logic [NUM_VALVES-1:0] v;
        v = ~open_mask(s);
        if (s == MIX) begin
            v[V_PUMP1] = pumps[2];
            v[V_PUMP2] = pumps[1];
            v[V_PUMP3] = pumps[0];
        end
        return v;
    endfunction

    peristaltic_phase_gen #(
        .PHASE_CYC   (PHASE_CYC),
        .MIX_STROKES (MIX_STROKES)
    ) u_phase_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      ((state_q == MIX) && !abort),
        .clear       ((state_q != MIX) || abort),
        .hold        (hold_act),
        .pump        (pump),
        .stroke_done (stroke_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            valves_q <= '1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_next;
            cnt_q    <= cnt_next;
            valves_q <= valves_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // MIX exits on the phase generator's last stroke; other timed states on the down-counter.
    // A done pulse in IDLE blocks start for that cycle, so a held start restarts one cycle later.
    always_comb begin
        state_next = state_q;
        cnt_next   = cnt_q;
        if (abort_run) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (!hold_act) begin
            case (state_q)
                IDLE: begin
                    if (start && !abort && !done_q) begin
                        state_next = PRIME;
                        cnt_next   = dwell_m1(PRIME);
                    end
                end
                MIX: begin
                    if (stroke_done) begin
                        state_next = SEPARATE;
                        cnt_next   = dwell_m1(SEPARATE);
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        state_next = seq_next(state_q);
                        cnt_next   = dwell_m1(seq_next(state_q));
                    end else begin
                        cnt_next = cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        valves_d = valves_q;
        if (abort_run) begin
            valves_d = '1;
        end else if (!hold_act) begin
            valves_d = state_valves(state_q, pump);
        end
        busy_d = (state_next != IDLE);
        done_d = (state_q == ELUTE) && (state_next == IDLE) && !abort;
    end

    assign cells_in_ctrl  = valves_q[V_CELLS_IN];
    assign cells_out_ctrl = valves_q[V_CELLS_OUT];
    assign push_ctrl      = valves_q[V_PUSH];
    assign pump1          = valves_q[V_PUMP1];
    assign pump2          = valves_q[V_PUMP2];
    assign pump3          = valves_q[V_PUMP3];
    assign lysis_in_ctrl  = valves_q[V_LYSIS_IN];
    assign lysis_out_ctrl = valves_q[V_LYSIS_OUT];
    assign sep_ctrl       = valves_q[V_SEP];
    assign beads_ctrl     = valves_q[V_BEADS];
    assign sieve_ctrl     = valves_q[V_SIEVE];
    assign collect_ctrl   = valves_q[V_COLLECT];
    assign waste_ctrl     = valves_q[V_WASTE];
    assign busy           = busy_q;
    assign done           = done_q;
    assign state          = state_q;

endmodule
